// File: rtl/mem_stage_if.sv
// Data-memory bus between the pipeline MEM stage and the data memory.
// The stage is the master; dmem_ack is a single-cycle completion pulse.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory handshake with wait states, branch/jump resolution, MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to suppress misaligned word accesses and raise misalign_o.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        ALUZero_in,
    input  logic        Jump_i,
    input  logic [31:0] IDAdder_in,
    input  logic [31:0] RD2_i,
    input  logic [31:0] ALU_i,
    input  logic [31:0] jumpaddr_i,
    input  logic [4:0]  rt_rd_i,
    mem_stage_if.master dmem,
    output logic        stall_o,
    output logic        PCSrc_o,
    output logic [31:0] branch_target_o,
    output logic        Jump_o,
    output logic [31:0] jumpaddr_o,
    output logic        flush_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALU_o,
    output logic [4:0]  rt_rd_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic misalign_s;
    logic mem_op_s;
    logic req_s;
    logic stall_s;
    logic rd_ack_s;

    function automatic logic word_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Classify the incoming instruction; misaligned ops are dropped only when the check is built in.
    always_comb begin
        misalign_s = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = (MemRead_i | MemWrite_i) & word_misaligned(ALU_i);
`endif
        mem_op_s = (MemRead_i | MemWrite_i) & ~misalign_s;
    end

    // Access state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and request; an ack in IDLE without an op is spurious and ignored.
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = mem_op_s;
                if (mem_op_s && !dmem.dmem_ack) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem.dmem_ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: begin
                next_state_s = IDLE;
                req_s        = 1'b0;
            end
        endcase
    end

    // Bus drive and stall; write wins over read when both are flagged.
    always_comb begin
        stall_s  = req_s & ~dmem.dmem_ack;
        rd_ack_s = req_s & dmem.dmem_ack & MemRead_i & ~MemWrite_i;
    end

    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = req_s ? MemWrite_i : 1'b0;
    assign dmem.dmem_addr  = req_s ? ALU_i : 32'h0000_0000;
    assign dmem.dmem_wdata = req_s ? RD2_i : 32'h0000_0000;
    assign stall_o         = stall_s;

    // Control-flow resolution is purely combinational on the EX/MEM contents.
    assign PCSrc_o         = (branch_i & ALUZero_in) | (bne_i & ~ALUZero_in);
    assign branch_target_o = IDAdder_in;
    assign Jump_o          = Jump_i;
    assign jumpaddr_o      = jumpaddr_i;
    assign flush_o         = PCSrc_o | Jump_i;

    // MEM/WB register: capture when not stalled, otherwise insert a bubble holding the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            ReadData_o <= 32'h0000_0000;
            ALU_o      <= 32'h0000_0000;
            rt_rd_o    <= 5'd0;
        end else if (stall_s) begin
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            rt_rd_o    <= 5'd0;
        end else begin
            MemtoReg_o <= MemtoReg_i;
            RegWrite_o <= RegWrite_i & ~misalign_s;
            ALU_o      <= ALU_i;
            rt_rd_o    <= rt_rd_i;
            if (rd_ack_s) begin
                ReadData_o <= dmem.dmem_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle flag for a suppressed misaligned access.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else if (stall_s) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= misalign_s;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i;
    logic        branch_i, bne_i, ALUZero_in, Jump_i;
    logic [31:0] IDAdder_in, RD2_i, ALU_i, jumpaddr_i;
    logic [4:0]  rt_rd_i;
    logic        stall_o, PCSrc_o, Jump_o, flush_o;
    logic [31:0] branch_target_o, jumpaddr_o;
    logic        MemtoReg_o, RegWrite_o;
    logic [31:0] ReadData_o, ALU_o;
    logic [4:0]  rt_rd_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk(clk), .rst(rst),
        .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .branch_i(branch_i), .bne_i(bne_i), .ALUZero_in(ALUZero_in), .Jump_i(Jump_i),
        .IDAdder_in(IDAdder_in), .RD2_i(RD2_i), .ALU_i(ALU_i), .jumpaddr_i(jumpaddr_i),
        .rt_rd_i(rt_rd_i),
        .dmem(dmem_bus),
        .stall_o(stall_o), .PCSrc_o(PCSrc_o), .branch_target_o(branch_target_o),
        .Jump_o(Jump_o), .jumpaddr_o(jumpaddr_o), .flush_o(flush_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ReadData_o(ReadData_o),
        .ALU_o(ALU_o), .rt_rd_o(rt_rd_o)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference MEM/WB contents
    logic        m_memtoreg, m_regwrite, m_misalign;
    logic [31:0] m_readdata, m_alu;
    logic [4:0]  m_rtrd;
    logic        spur_ack;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_memtoreg = 1'b0; m_regwrite = 1'b0; m_misalign = 1'b0;
        m_readdata = 32'h0; m_alu = 32'h0; m_rtrd = 5'd0;
    endtask

    task automatic clear_inputs();
        MemtoReg_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        branch_i = 1'b0; bne_i = 1'b0; ALUZero_in = 1'b0; Jump_i = 1'b0;
        IDAdder_in = 32'h0; RD2_i = 32'h0; ALU_i = 32'h0; jumpaddr_i = 32'h0;
        rt_rd_i = 5'd0; spur_ack = 1'b0;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    endtask

    task automatic check_regs();
        check_eq("memtoreg_o", MemtoReg_o, m_memtoreg);
        check_eq("regwrite_o", RegWrite_o, m_regwrite);
        check_eq("readdata_o", ReadData_o, m_readdata);
        check_eq("alu_o", ALU_o, m_alu);
        check_eq("rt_rd_o", rt_rd_o, m_rtrd);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("misalign_o", misalign_o, m_misalign);
`endif
    endtask

    // One instruction held on the inputs; memory answers after lat wait cycles.
    task automatic run_instr(input int lat, input logic [31:0] rdata);
        logic op, misal, taken;
        misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = (MemRead_i || MemWrite_i) && (ALU_i[1:0] != 2'b00);
`endif
        op = (MemRead_i || MemWrite_i) && !misal;
        if (!op) lat = 0;
        taken = branch_i ? ALUZero_in : (bne_i ? !ALUZero_in : 1'b0);
        if (branch_i && bne_i) taken = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            dmem_bus.dmem_rdata = rdata;
            dmem_bus.dmem_ack   = op ? (c == lat) : spur_ack;
            @(negedge clk);
            check_eq("dmem_req", dmem_bus.dmem_req, op);
            check_eq("stall_o", stall_o, op && (c < lat));
            check_eq("dmem_we", dmem_bus.dmem_we, op && MemWrite_i);
            check_eq("dmem_addr", dmem_bus.dmem_addr, op ? ALU_i : 32'h0);
            check_eq("dmem_wdata", dmem_bus.dmem_wdata, op ? RD2_i : 32'h0);
            check_eq("pcsrc_o", PCSrc_o, taken);
            check_eq("flush_o", flush_o, taken || Jump_i);
            check_eq("branch_target_o", branch_target_o, IDAdder_in);
            check_eq("jump_o", Jump_o, Jump_i);
            check_eq("jumpaddr_o", jumpaddr_o, jumpaddr_i);
            if (op && (c < lat)) begin
                m_regwrite = 1'b0; m_memtoreg = 1'b0; m_rtrd = 5'd0; m_misalign = 1'b0;
            end else begin
                m_memtoreg = MemtoReg_i;
                m_regwrite = RegWrite_i && !misal;
                m_alu      = ALU_i;
                m_rtrd     = rt_rd_i;
                m_misalign = misal;
                if (op && MemRead_i && !MemWrite_i) m_readdata = rdata;
            end
            @(posedge clk); #1;
            check_regs();
        end
        dmem_bus.dmem_ack = 1'b0;
    endtask

    initial begin
        int kind;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check_eq("reset_req", dmem_bus.dmem_req, 1'b0);
        rst = 1'b0;

        // lw with zero-wait memory
        MemRead_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1; ALU_i = 32'h10; rt_rd_i = 5'd3;
        run_instr(0, 32'hDEAD_BEEF);
        check_eq("lw_readdata", ReadData_o, 32'hDEAD_BEEF);
        check_eq("lw_regwrite", RegWrite_o, 1'b1);
        check_eq("lw_memtoreg", MemtoReg_o, 1'b1);

        // sw acked after three wait cycles
        clear_inputs();
        MemWrite_i = 1'b1; ALU_i = 32'h20; RD2_i = 32'h55; rt_rd_i = 5'd9;
        run_instr(3, 32'h1234_5678);
        check_eq("sw_readdata_hold", ReadData_o, 32'hDEAD_BEEF);

        // beq taken, then bne not taken on zero
        clear_inputs();
        branch_i = 1'b1; ALUZero_in = 1'b1; IDAdder_in = 32'h40;
        #1;
        check_eq("beq_pcsrc", PCSrc_o, 1'b1);
        check_eq("beq_target", branch_target_o, 32'h40);
        check_eq("beq_flush", flush_o, 1'b1);
        run_instr(0, 32'h0);
        branch_i = 1'b0; bne_i = 1'b1; ALUZero_in = 1'b1;
        #1;
        check_eq("bne_pcsrc", PCSrc_o, 1'b0);
        run_instr(0, 32'h0);

        // reset while waiting on a read; the late ack must not be captured
        clear_inputs();
        MemRead_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1; ALU_i = 32'h100; rt_rd_i = 5'd7;
        @(negedge clk);
        check_eq("wait_stall", stall_o, 1'b1);
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_eq("wait_req_held", dmem_bus.dmem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("late_ack_req", dmem_bus.dmem_req, 1'b0);
        check_eq("late_ack_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        check_regs();
        dmem_bus.dmem_ack = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        clear_inputs();
        MemRead_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1; ALU_i = 32'h13; rt_rd_i = 5'd4;
        run_instr(2, 32'hBAD0_BAD0);
        check_eq("mis_flag", misalign_o, 1'b1);
        check_eq("mis_regwrite", RegWrite_o, 1'b0);
        clear_inputs();
        run_instr(0, 32'h0);
`endif

        // randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            kind       = $urandom_range(0, 3);
            MemRead_i  = (kind == 1) || (kind == 3);
            MemWrite_i = (kind == 2) || (kind == 3);
            MemtoReg_i = 1'($urandom_range(0, 1));
            RegWrite_i = 1'($urandom_range(0, 1));
            branch_i   = 1'($urandom_range(0, 1));
            bne_i      = 1'($urandom_range(0, 1));
            ALUZero_in = 1'($urandom_range(0, 1));
            Jump_i     = ($urandom_range(0, 7) == 0);
            IDAdder_in = $urandom;
            RD2_i      = $urandom;
            jumpaddr_i = $urandom;
            rt_rd_i    = 5'($urandom_range(0, 31));
            ALU_i      = $urandom;
            if ($urandom_range(0, 3) != 0) ALU_i[1:0] = 2'b00;
            spur_ack   = 1'($urandom_range(0, 1));
            run_instr($urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
